// File: rtl/ab_all_frame_er.sv
// Purpose: Alice/Bob block-parity + bisection error reconciliation over FRAME_NUM frames, writing both keys to BRAM.
// Latency: per word LOAD+PARITY+WRITE plus 3 cycles per mismatching parity block; VERIFY+REPORT per frame, DONE per run.
// Backpressure: none; the BRAM ports always accept writes, runs are triggered by a start_switch rising edge only.
module ab_all_frame_er #(
   parameter int FRAME_NUM        = 4,
   parameter int FRAME_WORDS      = 64,
   parameter int ERR_EVERY        = 4,
   parameter int DOUBLE_ERR_FRAME = 2,
   parameter int LEAK_W           = 16,
   parameter int ERR_W            = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_switch,
   input  logic              sifted_key_addr_index,
   output logic              finish_A_all_frame_ER,
   output logic              finish_B_all_frame_ER,
   output logic              Areconciledkey_clka,
   output logic              Areconciledkey_ena,
   output logic              Areconciledkey_wea,
   output logic [14:0]       Areconciledkey_addra,
   output logic [63:0]       Areconciledkey_dina,
   output logic              Breconciledkey_clka,
   output logic              Breconciledkey_ena,
   output logic              Breconciledkey_wea,
   output logic [14:0]       Breconciledkey_addra,
   output logic [63:0]       Breconciledkey_dina,
   output logic [LEAK_W-1:0] single_frame_leaked_info,
   output logic [ERR_W-1:0]  single_frame_error_count,
   output logic              single_frame_parameter_valid,
   output logic              A_single_frame_error_verification_fail,
   output logic              B_single_frame_error_verification_fail
);

   localparam logic [13:0] LAST_WORD  = 14'(FRAME_WORDS - 1);
   localparam logic [13:0] LAST_FRAME = 14'(FRAME_NUM - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PARITY, S_BISECT, S_WRITE, S_VERIFY, S_REPORT, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              start_sync_q, start_prev_q;
   logic [13:0]       frame_q, frame_d;
   logic [13:0]       word_q, word_d;
   logic [13:0]       lin_q, lin_d;
   logic [63:0]       a_q, a_d;
   logic [63:0]       b_q, b_d;
   logic [7:0]        mask_q, mask_d;
   logic [1:0]        step_q, step_d;
   logic [5:0]        base_q, base_d;
   logic [LEAK_W-1:0] leak_q, leak_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [31:0]       cs_a_q, cs_a_d;
   logic [31:0]       cs_b_q, cs_b_d;
   logic              fail_q, fail_d;

   // Saturating add for the leak counter.
   function automatic logic [LEAK_W-1:0] leak_add(input logic [LEAK_W-1:0] v,
                                                  input logic [LEAK_W-1:0] inc);
      logic [LEAK_W:0] s;
      s = {1'b0, v} + {1'b0, inc};
      return s[LEAK_W] ? '1 : s[LEAK_W-1:0];
   endfunction

   // Index of the lowest set bit; bisection serves blocks lowest first.
   function automatic logic [2:0] low_idx(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   logic        start_edge;
   logic [31:0] hi_w;
   logic [63:0] a_gen, b_gen, err_mask;
   logic [5:0]  ebit;
   logic [7:0]  pmask;
   logic [2:0]  blk;
   logic [5:0]  cur_base, nxt_base;
   logic [3:0]  half;
   logic [63:0] diff;
   logic        lower_odd;

   assign start_edge = start_sync_q & ~start_prev_q;

   // Key sources, block parity compare and one bisection step, all from registered state.
   always_comb begin
      hi_w     = {16'hA5C3, frame_q[7:0], word_q[7:0]};
      a_gen    = {hi_w, ~hi_w};
      ebit     = word_q[5:0] * 6'd7;
      err_mask = '0;
      if ((32'(word_q) % ERR_EVERY) == 0) err_mask[ebit] = 1'b1;
      if ((DOUBLE_ERR_FRAME < FRAME_NUM) && (32'(frame_q) == DOUBLE_ERR_FRAME) && (word_q == '0))
         err_mask[1] = ~err_mask[1];
      b_gen = a_gen ^ err_mask;

      for (int b = 0; b < 8; b++) pmask[b] = (^a_q[8*b +: 8]) ^ (^b_q[8*b +: 8]);

      blk       = low_idx(mask_q);
      cur_base  = (step_q == 2'd0) ? {blk, 3'b000} : base_q;
      half      = 4'd4 >> step_q;
      diff      = a_q ^ b_q;
      lower_odd = ^((diff >> cur_base) & ((64'd1 << half) - 64'd1));
      nxt_base  = lower_odd ? cur_base : cur_base + 6'(half);
   end

   // Reconciliation FSM: next state and all datapath updates.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      word_d  = word_q;
      lin_d   = lin_q;
      a_d     = a_q;
      b_d     = b_q;
      mask_d  = mask_q;
      step_d  = step_q;
      base_d  = base_q;
      leak_d  = leak_q;
      err_d   = err_q;
      cs_a_d  = cs_a_q;
      cs_b_d  = cs_b_q;
      fail_d  = fail_q;
      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               frame_d = '0;
               word_d  = '0;
               lin_d   = '0;
               leak_d  = '0;
               err_d   = '0;
               cs_a_d  = '0;
               cs_b_d  = '0;
               fail_d  = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            a_d     = a_gen;
            b_d     = b_gen;
            state_d = S_PARITY;
         end
         S_PARITY: begin
            mask_d  = pmask;
            step_d  = 2'd0;
            leak_d  = leak_add(leak_q, LEAK_W'(8));
            state_d = (pmask != 8'd0) ? S_BISECT : S_WRITE;
         end
         S_BISECT: begin
            leak_d = leak_add(leak_q, LEAK_W'(1));
            if (step_q == 2'd2) begin
               b_d         = b_q ^ (64'd1 << nxt_base);
               mask_d[blk] = 1'b0;
               if (err_q != '1) err_d = err_q + 1'b1;
               step_d  = 2'd0;
               state_d = ((mask_q & ~(8'd1 << blk)) != 8'd0) ? S_BISECT : S_WRITE;
            end else begin
               step_d = step_q + 2'd1;
               base_d = nxt_base;
            end
         end
         S_WRITE: begin
            cs_a_d = cs_a_q ^ a_q[63:32] ^ a_q[31:0];
            cs_b_d = cs_b_q ^ b_q[63:32] ^ b_q[31:0];
            lin_d  = lin_q + 14'd1;
            if (word_q == LAST_WORD) begin
               state_d = S_VERIFY;
            end else begin
               word_d  = word_q + 14'd1;
               state_d = S_LOAD;
            end
         end
         S_VERIFY: begin
            leak_d  = leak_add(leak_q, LEAK_W'(32));
            fail_d  = (cs_a_q != cs_b_q);
            state_d = S_REPORT;
         end
         S_REPORT: begin
            leak_d = '0;
            err_d  = '0;
            cs_a_d = '0;
            cs_b_d = '0;
            fail_d = 1'b0;
            word_d = '0;
            if (frame_q == LAST_FRAME) begin
               state_d = S_DONE;
            end else begin
               frame_d = frame_q + 14'd1;
               state_d = S_LOAD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         start_sync_q <= 1'b0;
         start_prev_q <= 1'b0;
         frame_q      <= '0;
         word_q       <= '0;
         lin_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mask_q       <= '0;
         step_q       <= '0;
         base_q       <= '0;
         leak_q       <= '0;
         err_q        <= '0;
         cs_a_q       <= '0;
         cs_b_q       <= '0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_sync_q <= start_switch;
         start_prev_q <= start_sync_q;
         frame_q      <= frame_d;
         word_q       <= word_d;
         lin_q        <= lin_d;
         a_q          <= a_d;
         b_q          <= b_d;
         mask_q       <= mask_d;
         step_q       <= step_d;
         base_q       <= base_d;
         leak_q       <= leak_d;
         err_q        <= err_d;
         cs_a_q       <= cs_a_d;
         cs_b_q       <= cs_b_d;
         fail_q       <= fail_d;
      end
   end

   logic wr, rep;
   assign wr  = (state_q == S_WRITE);
   assign rep = (state_q == S_REPORT);

   assign Areconciledkey_clka  = clk;
   assign Breconciledkey_clka  = clk;
   assign Areconciledkey_ena   = wr;
   assign Areconciledkey_wea   = wr;
   assign Breconciledkey_ena   = wr;
   assign Breconciledkey_wea   = wr;
   assign Areconciledkey_addra = wr ? {sifted_key_addr_index, lin_q} : 15'd0;
   assign Breconciledkey_addra = wr ? {sifted_key_addr_index, lin_q} : 15'd0;
   assign Areconciledkey_dina  = wr ? a_q : 64'd0;
   assign Breconciledkey_dina  = wr ? b_q : 64'd0;

   assign single_frame_parameter_valid           = rep;
   assign single_frame_leaked_info               = rep ? leak_q : '0;
   assign single_frame_error_count               = rep ? err_q : '0;
   assign A_single_frame_error_verification_fail = rep & fail_q;
   assign B_single_frame_error_verification_fail = rep & fail_q;

   assign finish_A_all_frame_ER = (state_q == S_DONE);
   assign finish_B_all_frame_ER = (state_q == S_DONE);

endmodule

// File: tb/tb_ab_all_frame_er.sv
// Purpose: self-checking bench for ab_all_frame_er against a block-parity reference model.
// Latency: runs complete within a bounded cycle budget; expiry is reported as a failure.
// Backpressure: not applicable; all outputs are observed on the falling clock edge.
module tb_ab_all_frame_er;

   localparam int FN  = 4;
   localparam int FWD = 64;
   localparam int NW  = FN * FWD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_switch = 1'b0;
   logic        idx = 1'b0;
   logic        fin_a_o, fin_b_o;
   logic        a_clka, a_ena, a_wea, b_clka, b_ena, b_wea;
   logic [14:0] a_addr, b_addr;
   logic [63:0] a_dina, b_dina;
   logic [15:0] leak_o;
   logic [11:0] err_o;
   logic        valid_o, fa_o, fb_o;

   ab_all_frame_er dut (
      .clk(clk), .rst_n(rst_n), .start_switch(start_switch),
      .sifted_key_addr_index(idx),
      .finish_A_all_frame_ER(fin_a_o), .finish_B_all_frame_ER(fin_b_o),
      .Areconciledkey_clka(a_clka), .Areconciledkey_ena(a_ena), .Areconciledkey_wea(a_wea),
      .Areconciledkey_addra(a_addr), .Areconciledkey_dina(a_dina),
      .Breconciledkey_clka(b_clka), .Breconciledkey_ena(b_ena), .Breconciledkey_wea(b_wea),
      .Breconciledkey_addra(b_addr), .Breconciledkey_dina(b_dina),
      .single_frame_leaked_info(leak_o), .single_frame_error_count(err_o),
      .single_frame_parameter_valid(valid_o),
      .A_single_frame_error_verification_fail(fa_o),
      .B_single_frame_error_verification_fail(fb_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Expected report table for the default configuration, derived by hand.
   typedef struct {
      int leak;
      int err;
      bit fail;
   } rep_vec_t;
   rep_vec_t rep_tab[FN];

   // Reference model: sifted keys, block-parity correction, checksums.
   logic [63:0] m_a[NW];
   logic [63:0] m_b[NW];
   int          m_leak[FN];
   int          m_err[FN];
   bit          m_fail[FN];

   function automatic logic [63:0] alice(input int f, input int w);
      logic [31:0] h;
      h = {16'hA5C3, 8'(f), 8'(w)};
      return {h, ~h};
   endfunction

   task automatic build_model();
      logic [63:0] a, b;
      logic [31:0] ca, cb;
      logic [7:0]  d;
      int corr;
      for (int f = 0; f < FN; f++) begin
         ca = '0; cb = '0; corr = 0;
         for (int w = 0; w < FWD; w++) begin
            a = alice(f, w);
            b = a;
            if (w % 4 == 0) b[(w * 7) % 64] = ~b[(w * 7) % 64];
            if (f == 2 && w == 0) b[1] = ~b[1];
            for (int k = 0; k < 8; k++) begin
               d = 8'((a ^ b) >> (8 * k));
               if ($countones(d) % 2 == 1) begin
                  corr++;
                  if ($countones(d) == 1) b = b ^ (64'(d) << (8 * k));
               end
            end
            m_a[f*FWD+w] = a;
            m_b[f*FWD+w] = b;
            ca = ca ^ a[63:32] ^ a[31:0];
            cb = cb ^ b[63:32] ^ b[31:0];
         end
         m_err[f]  = corr;
         m_leak[f] = 8 * FWD + 3 * corr + 32;
         m_fail[f] = (ca != cb);
      end
   endtask

   // Observation of writes, report strobes and finish pulses.
   int          cyc = 0;
   logic [14:0] wq_addr[$];
   logic [63:0] wq_a[$];
   logic [63:0] wq_b[$];
   int          rq_leak[$];
   int          rq_err[$];
   bit          rq_fa[$];
   bit          rq_fb[$];
   int          rq_cyc[$];
   int          fin_a = 0, fin_b = 0, fin_cyc = 0, fin_skew = 0, port_bad = 0;

   always @(negedge clk) begin
      cyc++;
      if (a_ena || b_ena) begin
         wq_addr.push_back(a_addr);
         wq_a.push_back(a_dina);
         wq_b.push_back(b_dina);
         if (!(a_ena && a_wea && b_ena && b_wea) || a_addr != b_addr) port_bad++;
      end
      if (valid_o) begin
         rq_leak.push_back(int'(leak_o));
         rq_err.push_back(int'(err_o));
         rq_fa.push_back(fa_o);
         rq_fb.push_back(fb_o);
         rq_cyc.push_back(cyc);
      end
      if (fin_a_o) begin fin_a++; fin_cyc = cyc; end
      if (fin_b_o) fin_b++;
      if (fin_a_o != fin_b_o) fin_skew++;
   end

   task automatic clear_obs();
      wq_addr.delete(); wq_a.delete(); wq_b.delete();
      rq_leak.delete(); rq_err.delete(); rq_fa.delete(); rq_fb.delete(); rq_cyc.delete();
      fin_a = 0; fin_b = 0; fin_skew = 0; port_bad = 0;
   endtask

   task automatic run_and_check(input logic ix, input bit use_table);
      int n_addr, n_a, n_b;
      clear_obs();
      @(negedge clk);
      idx = ix;
      start_switch = 1'b1;
      for (int i = 0; i < 5000 && fin_a == 0; i++) @(negedge clk);
      chk("run_finished_in_budget", 64'(fin_a > 0), 64'd1);
      // start_switch stays high: the run must not restart.
      repeat (300) @(negedge clk);
      chk("write_count", 64'(wq_addr.size()), 64'(NW));
      n_addr = 0; n_a = 0; n_b = 0;
      for (int i = 0; i < wq_addr.size() && i < NW; i++) begin
         if (wq_addr[i] !== {ix, 14'(i)}) n_addr++;
         if (wq_a[i] !== m_a[i]) n_a++;
         if (wq_b[i] !== m_b[i]) n_b++;
      end
      chk("addr_mismatches", 64'(n_addr), 64'd0);
      chk("alice_data_mismatches", 64'(n_a), 64'd0);
      chk("bob_data_mismatches", 64'(n_b), 64'd0);
      chk("port_strobe_errors", 64'(port_bad), 64'd0);
      chk("report_count", 64'(rq_leak.size()), 64'(FN));
      for (int f = 0; f < FN && f < rq_leak.size(); f++) begin
         chk($sformatf("leak_f%0d", f), 64'(rq_leak[f]), 64'(m_leak[f]));
         chk($sformatf("errcnt_f%0d", f), 64'(rq_err[f]), 64'(m_err[f]));
         chk($sformatf("failA_f%0d", f), 64'(rq_fa[f]), 64'(m_fail[f]));
         chk($sformatf("failB_f%0d", f), 64'(rq_fb[f]), 64'(m_fail[f]));
         if (use_table) begin
            chk($sformatf("tab_leak_f%0d", f), 64'(rq_leak[f]), 64'(rep_tab[f].leak));
            chk($sformatf("tab_err_f%0d", f), 64'(rq_err[f]), 64'(rep_tab[f].err));
            chk($sformatf("tab_fail_f%0d", f), 64'(rq_fa[f]), 64'(rep_tab[f].fail));
         end
      end
      chk("finish_A_pulses", 64'(fin_a), 64'd1);
      chk("finish_B_pulses", 64'(fin_b), 64'd1);
      chk("finish_skew", 64'(fin_skew), 64'd0);
      if (rq_cyc.size() == FN) chk("finish_after_last_strobe", 64'(fin_cyc - rq_cyc[FN-1]), 64'd1);
      start_switch = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_quiet_outputs(input string tag);
      chk({tag, "_enables"}, {60'd0, a_ena, a_wea, b_ena, b_wea}, 64'd0);
      chk({tag, "_addr"}, {34'd0, a_addr, b_addr}, 64'd0);
      chk({tag, "_dina_or"}, a_dina | b_dina, 64'd0);
      chk({tag, "_report"}, {33'd0, valid_o, fa_o, fb_o, leak_o, err_o}, 64'd0);
      chk({tag, "_finish"}, {62'd0, fin_a_o, fin_b_o}, 64'd0);
   endtask

   task automatic reset_mid_run(input int after_writes);
      clear_obs();
      @(negedge clk);
      idx = 1'b0;
      start_switch = 1'b1;
      for (int i = 0; i < 3000 && wq_addr.size() < after_writes; i++) @(negedge clk);
      chk("mid_run_reached", 64'(wq_addr.size() >= after_writes), 64'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_quiet_outputs("mid_run_reset");
      start_switch = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
      repeat (300) @(negedge clk);
      chk("no_writes_after_reset", 64'(wq_addr.size()), 64'd0);
      chk("no_reports_after_reset", 64'(rq_leak.size()), 64'd0);
   endtask

   initial begin
      rep_tab[0] = '{leak: 592, err: 16, fail: 1'b0};
      rep_tab[1] = '{leak: 592, err: 16, fail: 1'b0};
      rep_tab[2] = '{leak: 589, err: 15, fail: 1'b1};
      rep_tab[3] = '{leak: 592, err: 16, fail: 1'b0};
      build_model();

      #1 rst_n = 1'b0;
      #3 check_quiet_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_quiet_outputs("idle");

      // Default run with hand-derived expectations.
      run_and_check(1'b0, 1'b1);
      if (wq_a.size() == NW) begin
         int n_diff;
         chk("f0w0_alice_dina", wq_a[0], 64'hA5C3_0000_5A3C_FFFF);
         chk("f2w0_bob_vs_alice", wq_a[2*FWD] ^ wq_b[2*FWD], 64'h3);
         n_diff = 0;
         for (int i = 0; i < NW; i++)
            if (i / FWD != 2 && wq_a[i] !== wq_b[i]) n_diff++;
         chk("frames013_bob_eq_alice", 64'(n_diff), 64'd0);
      end

      reset_mid_run(100);
      run_and_check(1'b1, 1'b1);

      for (int r = 0; r < 2; r++) begin
         repeat ($urandom_range(1, 20)) @(negedge clk);
         reset_mid_run(int'($urandom_range(5, 250)));
         run_and_check(1'($urandom_range(0, 1)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
